result_readback_master: RTL and testbench

RESULT_READBACK_MASTER -- requirements
Module: result_readback_master

---
 rtl/rrb_pkg.sv | 21 ++
 rtl/sync_fwft_fifo.sv | 48 ++++
 rtl/result_readback_master.sv | 154 +++++++++++++++
 tb/tb_result_readback_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrb_pkg.sv
// Shared types and limits for the result readback master.
package rrb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rrb_state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int clamp_latency(input int lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of 2.
module sync_fwft_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/result_readback_master.sv
// Reads a window of a RAM slave over Avalon-MM and streams the words out with
// a last marker, throttling reads so the output FIFO can never overflow.
module result_readback_master
  import rrb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  avalon_clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int LAT = clamp_latency(READ_LATENCY);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  rrb_state_e            state;
  logic [ADDR_WIDTH:0]   wc_q, rem, cap_idx;
  logic [LAT:1]          vld_pipe;
  logic [CW-1:0]         inflight, fifo_count;
  logic                  last_seen;
  logic                  cap, pop, cap_last;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic [CW:0]           credit_room, credit_need;
  logic                  credit_ok, issue_go, drain_ok;

  assign cap      = vld_pipe[LAT];
  assign pop      = !fifo_empty && out_ready;
  assign cap_last = (cap_idx == wc_q - 1'b1);

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
  assign out_last  = !fifo_empty && fifo_rdata[DATA_WIDTH];

  // Slots free after this cycle's pop must exceed every read already committed,
  // counting the one on the bus now; captures move a word from one side to the other.
  assign credit_room = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} + {{CW{1'b0}}, pop};
  assign credit_need = {1'b0, inflight} + {{CW{1'b0}}, read};
  assign credit_ok   = !(fifo_full && !pop) && (credit_room > credit_need);
  assign issue_go    = (rem != '0) && credit_ok;

  // The final pop itself may close the job, saving a cycle of drain.
  assign drain_ok = (inflight == '0) && (fifo_count == CW'(pop)) &&
                    (last_seen || (pop && out_last));

  sync_fwft_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (avalon_clk),
    .rst_n   (resetn),
    .wr_en   (cap),
    .wr_data ({cap_last, readdata}),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  generate
    if (LAT == 1) begin : g_pipe1
      always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) vld_pipe <= '0;
        else         vld_pipe <= read;
      end
    end else begin : g_pipen
      always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) vld_pipe <= '0;
        else         vld_pipe <= {vld_pipe[LAT-1:1], read};
      end
    end
  endgenerate

  always_ff @(posedge avalon_clk or negedge resetn) begin
    if (!resetn) begin
      inflight <= '0;
      cap_idx  <= '0;
    end else begin
      inflight <= inflight + CW'(read) - CW'(cap);
      if (state == ST_IDLE && start) cap_idx <= '0;
      else if (cap)                  cap_idx <= cap_idx + 1'b1;
    end
  end

  always_ff @(posedge avalon_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      read      <= 1'b0;
      address   <= '0;
      wc_q      <= '0;
      rem       <= '0;
      last_seen <= 1'b0;
    end else begin
      if (pop && out_last) last_seen <= 1'b1;
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          read <= 1'b0;
          if (start) begin
            wc_q      <= word_count;
            address   <= base_addr;
            last_seen <= 1'b0;
            if (word_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              // Empty FIFO and no reads in flight: the first read needs no credit check.
              state <= ST_ISSUE;
              busy  <= 1'b1;
              read  <= 1'b1;
              rem   <= word_count - 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (read)     address <= address + 1'b1;
          read <= issue_go;
          if (issue_go) rem <= rem - 1'b1;
          if (rem == '0) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_ok) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_readback_master.sv
// Drives a latency-1 and a latency-3 instance side by side and scores both
// against a RAM model and the address/stream rules of a readback job.
module tb_result_readback_master;

  logic              clk = 1'b0;
  logic              resetn, start, rdy;
  logic [4:0]        base_addr;
  logic [5:0]        word_count;
  logic [1:0]        busy_s, done_s, read_s, valid_s, last_s;
  logic [1:0][4:0]   addr_s;
  logic [1:0][31:0]  rdata_s, odata_s;

  logic [31:0] mem [32];
  logic [31:0] p0;
  logic [31:0] p1 [3];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int n_rd[2] = '{0, 0}, n_out[2] = '{0, 0}, n_done[2] = '{0, 0};
  int n_ovf[2] = '{0, 0}, n_vld[2] = '{0, 0}, done_cyc[2] = '{0, 0};
  int base_rd[2] = '{0, 0}, base_out[2] = '{0, 0};
  logic [4:0]  rd_addr [2][1024];
  int          rd_cyc  [2][1024];
  logic [31:0] o_data  [2][1024];
  logic        o_last  [2][1024];
  int j_t0;
  int j_rd[2], j_out[2], j_done[2], j_ovf[2], j_vld[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_readback_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(4), .READ_LATENCY(1)) u_dut1 (
    .avalon_clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy_s[0]), .done(done_s[0]), .read(read_s[0]), .address(addr_s[0]), .readdata(rdata_s[0]),
    .out_data(odata_s[0]), .out_valid(valid_s[0]), .out_ready(rdy), .out_last(last_s[0]));

  result_readback_master #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(4), .READ_LATENCY(3)) u_dut3 (
    .avalon_clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy_s[1]), .done(done_s[1]), .read(read_s[1]), .address(addr_s[1]), .readdata(rdata_s[1]),
    .out_data(odata_s[1]), .out_valid(valid_s[1]), .out_ready(rdy), .out_last(last_s[1]));

  // RAM slaves: data appears 1 or 3 cycles after read; idle slots carry junk.
  always @(posedge clk) begin
    p0    <= read_s[0] ? mem[addr_s[0]] : $urandom();
    p1[0] <= read_s[1] ? mem[addr_s[1]] : $urandom();
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rdata_s[0] = p0;
  assign rdata_s[1] = p1[2];

  always @(negedge clk) begin
    if (resetn) begin
      for (int k = 0; k < 2; k++) begin
        if (read_s[k]) begin
          if (n_rd[k] < 1024) begin
            rd_addr[k][n_rd[k]] <= addr_s[k];
            rd_cyc[k][n_rd[k]]  <= cyc;
          end
          n_rd[k] <= n_rd[k] + 1;
        end
        if (valid_s[k] && rdy) begin
          if (n_out[k] < 1024) begin
            o_data[k][n_out[k]] <= odata_s[k];
            o_last[k][n_out[k]] <= last_s[k];
          end
          n_out[k] <= n_out[k] + 1;
        end
        if (valid_s[k]) n_vld[k] <= n_vld[k] + 1;
        if (done_s[k]) begin
          n_done[k]   <= n_done[k] + 1;
          done_cyc[k] <= cyc;
        end
        if (((n_rd[k] + int'(read_s[k]) - base_rd[k]) -
             (n_out[k] + int'(valid_s[k] && rdy) - base_out[k])) > 4)
          n_ovf[k] <= n_ovf[k] + 1;
      end
    end
  end

  task automatic rand_mem();
    for (int i = 0; i < 32; i++) mem[i] = $urandom();
  endtask

  task automatic run_job(input string nm, input int b, input int wc, input int mode, input bit poke);
    int kc, got;
    logic [4:0]  ea;
    logic [31:0] ed;
    rand_mem();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      j_rd[k] = n_rd[k]; j_out[k] = n_out[k]; j_done[k] = n_done[k];
      j_ovf[k] = n_ovf[k]; j_vld[k] = n_vld[k];
      base_rd[k] = n_rd[k]; base_out[k] = n_out[k];
    end
    j_t0 = cyc;
    start = 1'b1; base_addr = 5'(b); word_count = 6'(wc); rdy = (mode != 2);
    @(posedge clk); #1;
    start = 1'b0; base_addr = 5'($urandom()); word_count = 6'($urandom_range(1, 32));
    if (wc != 0)
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (busy_s[k] !== 1'b1) begin
          n_err++; $display("FAIL %s busy dut%0d: got %0b want 1", nm, k, busy_s[k]);
        end
      end
    kc = 0;
    while (!((n_done[0] > j_done[0]) && (n_done[1] > j_done[1])) && kc < 600) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom());
        2:       rdy = (kc >= 19);
        default: rdy = (kc % 2 == 0);
      endcase
      start = poke && (kc == 2);
      if (start) begin base_addr = 5'(b + 7); word_count = 6'd3; end
      @(posedge clk); #1; kc++;
    end
    start = 1'b0;
    n_cmp++;
    if (kc >= 600) begin n_err++; $display("FAIL %s timeout: got %0d cycles want <600", nm, kc); end
    rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (n_done[k] - j_done[k] != 1) begin
        n_err++; $display("FAIL %s done_pulses dut%0d: got %0d want 1", nm, k, n_done[k] - j_done[k]);
      end
      n_cmp++;
      if (n_rd[k] - j_rd[k] != wc) begin
        n_err++; $display("FAIL %s read_count dut%0d: got %0d want %0d", nm, k, n_rd[k] - j_rd[k], wc);
      end
      n_cmp++;
      if (n_out[k] - j_out[k] != wc) begin
        n_err++; $display("FAIL %s word_count dut%0d: got %0d want %0d", nm, k, n_out[k] - j_out[k], wc);
      end
      n_cmp++;
      if (n_ovf[k] != j_ovf[k]) begin
        n_err++; $display("FAIL %s outstanding dut%0d: got %0d violations want 0", nm, k, n_ovf[k] - j_ovf[k]);
      end
      got = n_rd[k] - j_rd[k];
      for (int i = 0; i < wc && i < got; i++) begin
        ea = 5'(b + i);
        n_cmp++;
        if (rd_addr[k][j_rd[k] + i] !== ea) begin
          n_err++; $display("FAIL %s addr[%0d] dut%0d: got %0d want %0d", nm, i, k, rd_addr[k][j_rd[k] + i], ea);
          break;
        end
      end
      got = n_out[k] - j_out[k];
      for (int i = 0; i < wc && i < got; i++) begin
        ed = mem[5'(b + i)];
        n_cmp++;
        if (o_data[k][j_out[k] + i] !== ed || o_last[k][j_out[k] + i] !== (i == wc - 1)) begin
          n_err++;
          $display("FAIL %s word[%0d] dut%0d: got %h/last=%0b want %h/last=%0b", nm, i, k,
                   o_data[k][j_out[k] + i], o_last[k][j_out[k] + i], ed, (i == wc - 1));
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({busy_s[k], done_s[k], read_s[k], valid_s[k], last_s[k]} !== 5'b0 ||
          addr_s[k] !== 5'd0 || odata_s[k] !== 32'd0) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got busy%0b done%0b read%0b valid%0b last%0b addr%0d data%h want all 0",
                 k, busy_s[k], done_s[k], read_s[k], valid_s[k], last_s[k], addr_s[k], odata_s[k]);
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    run_job("basic", 0, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_cyc[0][j_rd[0] + i] != j_t0 + 1 + i) begin
        n_err++; $display("FAIL basic read_cycle[%0d]: got %0d want %0d", i, rd_cyc[0][j_rd[0] + i], j_t0 + 1 + i);
      end
    end
    n_cmp++;
    if (done_cyc[0] - (j_t0 + 1) > 4 + 2) begin
      n_err++; $display("FAIL basic done_latency: got %0d want <=6", done_cyc[0] - (j_t0 + 1));
    end
  endtask

  task automatic test_wrap();
    run_job("wrap", 30, 4, 0, 1'b0);
  endtask

  task automatic test_zero();
    run_job("zero", $urandom_range(0, 31), 0, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (n_vld[k] != j_vld[k]) begin
        n_err++; $display("FAIL zero valid_cycles dut%0d: got %0d want 0", k, n_vld[k] - j_vld[k]);
      end
      n_cmp++;
      if (done_cyc[k] != j_t0 + 1) begin
        n_err++; $display("FAIL zero done_cycle dut%0d: got %0d want %0d", k, done_cyc[k], j_t0 + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    run_job("backpressure", $urandom_range(0, 31), 32, 2, 1'b0);
  endtask

  task automatic test_toggle();
    run_job("toggle", $urandom_range(0, 31), 8, 3, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_job("busy_ignore", $urandom_range(0, 31), 12, 0, 1'b1);
  endtask

  task automatic test_reset_midjob();
    int kk, s0;
    rand_mem();
    @(posedge clk); #1;
    s0 = n_rd[0];
    for (int k = 0; k < 2; k++) begin base_rd[k] = n_rd[k]; base_out[k] = n_out[k]; end
    start = 1'b1; base_addr = 5'd0; word_count = 6'd8; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kk = 0;
    while ((n_rd[0] - s0) < 3 && kk < 50) begin @(negedge clk); #1; kk++; end
    n_cmp++;
    if (kk >= 50) begin n_err++; $display("FAIL midjob wait_reads: got %0d want 3", n_rd[0] - s0); end
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({busy_s[k], done_s[k], read_s[k], valid_s[k], last_s[k]} !== 5'b0 ||
          addr_s[k] !== 5'd0 || odata_s[k] !== 32'd0) begin
        n_err++;
        $display("FAIL midjob_reset dut%0d: got busy%0b done%0b read%0b valid%0b last%0b addr%0d data%h want all 0",
                 k, busy_s[k], done_s[k], read_s[k], valid_s[k], last_s[k], addr_s[k], odata_s[k]);
      end
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    run_job("after_reset", 5, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++)
      run_job("random", $urandom_range(0, 31), $urandom_range(0, 32), $urandom_range(0, 3), 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_backpressure();
    test_toggle();
    test_busy_ignore();
    test_reset_midjob();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
